// File: rtl/vga_charbuf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_charbuf_arbiter
// Description : Single-port character RAM arbiter. Display fetch has fixed
//               priority over a clear-screen sequencer and a buffered host
//               write FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_charbuf_arbiter #(
    parameter int unsigned CHAR_COUNT = 2400,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_valid_o,
    output logic [7:0]        disp_data_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_char_i,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i
);

    localparam int unsigned       PTR_W         = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(CHAR_COUNT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic              disp_valid_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]        fifo_char_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, push, pop, head_in_range, clear_wr;

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == FIFO_FULL_CNT);
    assign wr_ready_o    = rst_n_i && !fifo_full && !clr_pend_q && (state_q != ST_CLEAR);
    assign push          = wr_valid_i && wr_ready_o;
    assign pop           = rst_n_i && !disp_req_i && (state_q == ST_IDLE) && !fifo_empty;
    assign clear_wr      = rst_n_i && !disp_req_i && (state_q == ST_CLEAR);
    assign head_in_range = (32'(fifo_addr_q[rd_ptr_q]) < CHAR_COUNT);

    assign busy_o        = clr_pend_q || (state_q == ST_CLEAR);
    assign disp_valid_o  = disp_valid_q;
    // RAM read data arrives one cycle after the fetch, so it is forwarded directly.
    assign disp_data_o   = disp_valid_q ? ram_rdata_i : 8'h00;

    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = 8'h00;
        if (!rst_n_i) begin
            ram_en_o = 1'b0;
        end else if (disp_req_i) begin
            ram_en_o   = 1'b1;
            ram_addr_o = disp_addr_i;
        end else if (state_q == ST_CLEAR) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = clear_addr_q;
            ram_wdata_o = FILL_CHAR;
        end else if (pop && head_in_range) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = fifo_addr_q[rd_ptr_q];
            ram_wdata_o = fifo_char_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_pend_d   = clr_pend_q;
        clear_addr_d = clear_addr_q;
        if (clr_req_i && !clr_pend_q && (state_q != ST_CLEAR)) begin
            clr_pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                // Queued host writes drain first so a clear always wins over them.
                if (clr_pend_q && fifo_empty) begin
                    state_d      = ST_CLEAR;
                    clr_pend_d   = 1'b0;
                    clear_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clear_wr) begin
                    if (clear_addr_q == LAST_ADDR) begin
                        state_d      = ST_IDLE;
                        clear_addr_d = '0;
                    end else begin
                        clear_addr_d = clear_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            clr_pend_q   <= 1'b0;
            clear_addr_q <= '0;
            disp_valid_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_pend_q   <= clr_pend_d;
            clear_addr_q <= clear_addr_d;
            disp_valid_q <= disp_req_i;
            count_q      <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr_i;
            fifo_char_q[wr_ptr_q] <= wr_char_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_charbuf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_charbuf_arbiter
// Description : Directed table-driven bench with a behavioural RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_charbuf_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req, disp_valid, wr_valid, wr_ready, clr_req, busy;
    logic        ram_en, ram_we;
    logic [11:0] disp_addr, wr_addr, ram_addr;
    logic [7:0]  disp_data, wr_char, ram_wdata, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t        wlog[$];
    logic [7:0] mem [0:4095];

    typedef struct {
        logic        dr;
        logic [11:0] da;
        logic        wv;
        logic [11:0] wa;
        logic [7:0]  wc;
        logic        rdy, en, we;
        logic [11:0] addr;
        logic [7:0]  wd;
        logic        dv, chk_dd;
        logic [7:0]  dd;
        logic        bsy;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    vga_charbuf_arbiter dut (
        .sys_clk_i   (clk),
        .rst_n_i     (rst_n),
        .disp_req_i  (disp_req),
        .disp_addr_i (disp_addr),
        .disp_valid_o(disp_valid),
        .disp_data_o (disp_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_char_i   (wr_char),
        .clr_req_i   (clr_req),
        .busy_o      (busy),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // Behavioural single-port RAM with one cycle read latency, plus a write log.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wlog.push_back('{a: ram_addr, d: ram_wdata});
        end
        if (ram_en && !ram_we) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_char   = '0;
        clr_req   = 1'b0;
    endtask

    task automatic add(input logic dr, input logic [11:0] da, input logic wv,
                       input logic [11:0] wa, input logic [7:0] wc,
                       input logic rdy, input logic en, input logic we,
                       input logic [11:0] addr, input logic [7:0] wd,
                       input logic dv, input logic chk_dd, input logic [7:0] dd,
                       input logic bsy);
        vq.push_back('{dr: dr, da: da, wv: wv, wa: wa, wc: wc, rdy: rdy, en: en,
                       we: we, addr: addr, wd: wd, dv: dv, chk_dd: chk_dd, dd: dd,
                       bsy: bsy});
    endtask

    task automatic run_clear(input string nm, input bit stretch, output int bc);
        bit prev_disp;
        bit done;
        bc        = 0;
        prev_disp = 1'b0;
        done      = 1'b0;
        to_drive();
        clr_req = 1'b1;
        to_sample();
        check({nm, "_busy_at_req"}, 32'(busy), 32'd0);
        for (int n = 0; n < 3000; n++) begin
            to_drive();
            clr_req   = 1'b0;
            disp_req  = stretch && (n == 10 || n == 20 || n == 30);
            disp_addr = '0;
            to_sample();
            if (prev_disp) begin
                check({nm, "_disp_valid"}, 32'(disp_valid), 32'd1);
                check({nm, "_disp_data"}, 32'(disp_data), 32'h20);
            end
            prev_disp = disp_req;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            bc++;
        end
        check({nm, "_busy_fell"}, 32'(done), 32'd1);
        to_drive();
        idle_inputs();
    endtask

    initial begin
        int base;
        int bc;
        int errs;
        bit found;
        bit accepted;
        int leak;

        idle_inputs();
        rst_n = 1'b0;

        // T1: reset
        for (int i = 0; i < 5; i++) begin
            to_drive();
            to_sample();
            check($sformatf("t1_reset_outs_%0d", i),
                  {wr_ready, busy, disp_valid, disp_data, ram_en, ram_we, ram_addr, ram_wdata},
                  32'd0);
        end
        to_drive();
        rst_n = 1'b1;
        to_sample();

        // T2 and T3 as cycle-by-cycle vectors
        add(0,   0, 0,  0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0, 8'h00, 0);
        add(0,   0, 1,  5, 8'h41, 1, 0, 0,   0, 8'h00, 0, 0, 8'h00, 0);
        add(0,   0, 0,  0, 8'h00, 1, 1, 1,   5, 8'h41, 0, 0, 8'h00, 0);
        add(1,   5, 0,  0, 8'h00, 1, 1, 0,   5, 8'h00, 0, 0, 8'h00, 0);
        add(0,   0, 0,  0, 8'h00, 1, 0, 0,   0, 8'h00, 1, 1, 8'h41, 0);
        add(1, 100, 1, 10, 8'h61, 1, 1, 0, 100, 8'h00, 0, 0, 8'h00, 0);
        add(1, 101, 1, 11, 8'h62, 1, 1, 0, 101, 8'h00, 1, 0, 8'h00, 0);
        add(1, 102, 1, 12, 8'h63, 1, 1, 0, 102, 8'h00, 1, 0, 8'h00, 0);
        add(1, 103, 1, 13, 8'h64, 1, 1, 0, 103, 8'h00, 1, 0, 8'h00, 0);
        for (int k = 0; k < 6; k++) begin
            add(1, 12'(104 + k), 1, 14, 8'h65, 0, 1, 0, 12'(104 + k), 8'h00, 1, 0, 8'h00, 0);
        end
        add(0,   0, 1, 14, 8'h65, 0, 1, 1,  10, 8'h61, 1, 0, 8'h00, 0);
        add(0,   0, 1, 14, 8'h65, 1, 1, 1,  11, 8'h62, 0, 0, 8'h00, 0);
        add(0,   0, 1, 15, 8'h66, 1, 1, 1,  12, 8'h63, 0, 0, 8'h00, 0);
        add(0,   0, 0,  0, 8'h00, 1, 1, 1,  13, 8'h64, 0, 0, 8'h00, 0);
        add(0,   0, 0,  0, 8'h00, 1, 1, 1,  14, 8'h65, 0, 0, 8'h00, 0);
        add(0,   0, 0,  0, 8'h00, 1, 1, 1,  15, 8'h66, 0, 0, 8'h00, 0);
        add(1,  12, 0,  0, 8'h00, 1, 1, 0,  12, 8'h00, 0, 0, 8'h00, 0);
        add(0,   0, 0,  0, 8'h00, 1, 0, 0,   0, 8'h00, 1, 1, 8'h63, 0);

        for (int i = 0; i < vq.size(); i++) begin
            to_drive();
            disp_req  = vq[i].dr;
            disp_addr = vq[i].da;
            wr_valid  = vq[i].wv;
            wr_addr   = vq[i].wa;
            wr_char   = vq[i].wc;
            to_sample();
            check($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vq[i].rdy));
            check($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vq[i].en));
            check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vq[i].we));
            if (vq[i].en) check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vq[i].addr));
            if (vq[i].we) check($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vq[i].wd));
            check($sformatf("v%0d_disp_valid", i), 32'(disp_valid), 32'(vq[i].dv));
            if (vq[i].chk_dd) check($sformatf("v%0d_disp_data", i), 32'(disp_data), 32'(vq[i].dd));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].bsy));
        end
        to_drive();
        idle_inputs();
        to_sample();

        // T4: plain clear, then a clear stretched by three display fetches
        base = wlog.size();
        run_clear("t4a", 1'b0, bc);
        check("t4a_busy_cycles", 32'(bc), 32'd2401);
        check("t4a_write_count", 32'(wlog.size() - base), 32'd2400);
        errs = 0;
        if (wlog.size() >= base + 2400) begin
            for (int k = 0; k < 2400; k++) begin
                if (wlog[base + k].a != 12'(k) || wlog[base + k].d != 8'h20) errs++;
            end
        end else begin
            errs = 2400;
        end
        check("t4a_write_sequence", 32'(errs), 32'd0);

        base = wlog.size();
        run_clear("t4b", 1'b1, bc);
        check("t4b_busy_cycles", 32'(bc), 32'd2404);
        check("t4b_write_count", 32'(wlog.size() - base), 32'd2400);

        // T5: queued writes, clear in the same cycle as the third one
        base = wlog.size();
        to_drive();
        disp_req = 1'b1; disp_addr = 12'd7;
        wr_valid = 1'b1; wr_addr = 12'd50; wr_char = 8'h71;
        to_sample();
        check("t5_wr1_ready", 32'(wr_ready), 32'd1);
        to_drive();
        wr_addr = 12'd51; wr_char = 8'h72;
        to_sample();
        check("t5_wr2_ready", 32'(wr_ready), 32'd1);
        to_drive();
        wr_addr = 12'd52; wr_char = 8'h73; clr_req = 1'b1;
        to_sample();
        check("t5_wr3_ready_with_clr", 32'(wr_ready), 32'd1);
        accepted = 1'b0;
        leak     = 0;
        for (int n = 0; n < 3000; n++) begin
            to_drive();
            disp_req = 1'b0; clr_req = 1'b0;
            wr_valid = 1'b1; wr_addr = 12'd53; wr_char = 8'h5A;
            to_sample();
            if (wr_ready && busy) leak++;
            if (wr_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        to_drive();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            to_drive();
            to_sample();
        end
        check("t5_late_write_accepted", 32'(accepted), 32'd1);
        check("t5_ready_while_busy", 32'(leak), 32'd0);
        check("t5_write_count", 32'(wlog.size() - base), 32'd2404);
        errs = 0;
        if (wlog.size() >= base + 2404) begin
            for (int k = 0; k < 3; k++) begin
                if (wlog[base + k].a != 12'(50 + k) || wlog[base + k].d != 8'(8'h71 + k)) errs++;
            end
            for (int k = 0; k < 2400; k++) begin
                if (wlog[base + 3 + k].a != 12'(k) || wlog[base + 3 + k].d != 8'h20) errs++;
            end
            if (wlog[base + 2403].a != 12'd53 || wlog[base + 2403].d != 8'h5A) errs++;
        end else begin
            errs = 2404;
        end
        check("t5_write_order", 32'(errs), 32'd0);
        errs = 0;
        for (int k = 0; k < 2400; k++) begin
            if (k != 53 && mem[k] != 8'h20) errs++;
        end
        check("t5_cells_filled", 32'(errs), 32'd0);
        check("t5_cell53", 32'(mem[53]), 32'h5A);
        to_drive();
        disp_req = 1'b1; disp_addr = 12'd52;
        to_sample();
        to_drive();
        idle_inputs();
        to_sample();
        check("t5_read52_valid", 32'(disp_valid), 32'd1);
        check("t5_read52_data", 32'(disp_data), 32'h20);

        // T6: out-of-range write is discarded, then reset aborts a clear
        base = wlog.size();
        to_drive();
        wr_valid = 1'b1; wr_addr = 12'd2400; wr_char = 8'h55;
        to_sample();
        check("t6_oor_ready", 32'(wr_ready), 32'd1);
        to_drive();
        idle_inputs();
        to_sample();
        check("t6_oor_no_ram_en", 32'(ram_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            to_drive();
            to_sample();
        end
        check("t6_oor_no_write", 32'(wlog.size() - base), 32'd0);

        base  = wlog.size();
        found = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            to_drive();
            clr_req = (n == 0);
            to_sample();
            if (ram_we && ram_addr == 12'd1000) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reached_1000", 32'(found), 32'd1);
        to_drive();
        rst_n = 1'b0;
        to_sample();
        check("t6_reset_outs", {30'd0, ram_en, wr_ready}, 32'd0);
        to_drive();
        to_sample();
        check("t6_reset_busy", 32'(busy), 32'd0);
        to_drive();
        rst_n = 1'b1;
        to_sample();
        check("t6_release_ready", 32'(wr_ready), 32'd1);
        check("t6_release_ram_en", 32'(ram_en), 32'd0);
        to_drive();
        to_sample();
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_fifo_empty_no_write", 32'(ram_en), 32'd0);
        check("t6_abort_write_count", 32'(wlog.size() - base), 32'd1001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
